// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 pixel serializer and its RZ encoder.
// Optional RGB-to-GRB reordering is enabled with WS2812_RGB_TO_GRB_EN.
package ws2812_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_TX    = 2'b01,
        CMD_RESET = 2'b10
    } ws2812_cmd_e;

    function automatic logic [15:0] swap_bytes(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

endpackage

// File: rtl/ws2812_pixel_skid.sv
// Holding slot behind the serializer shift register; owns pix_ready so the
// upstream stream sees a registered back-pressure signal.
module ws2812_pixel_skid #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [W-1:0] hold_data,
    output logic         hold_valid,
    output logic         hold_last,
    output logic         pix_ready
);

    logic hold_valid_next;

    // A pop and a push on the same edge leave the slot occupied by the new pixel.
    assign hold_valid_next = (hold_valid && !pop) || push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            pix_ready  <= 1'b0;
        end else begin
            if (push) begin
                hold_data <= push_data;
                hold_last <= push_last;
            end
            hold_valid <= hold_valid_next;
            pix_ready  <= !hold_valid_next;
        end
    end

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Pixel stream to WS2812 encoder feeder: two-pixel buffer, MSB-first bit shifter
// and TX/RESET/IDLE command generation. Define WS2812_RGB_TO_GRB_EN for RGB input.
module ws2812_pixel_serializer
    import ws2812_pkg::*;
#(
    parameter  int BITS_PER_PIXEL = 24,
    localparam int COUNTER_SIZE   = $clog2(BITS_PER_PIXEL + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BITS_PER_PIXEL-1:0] pix_data,
    input  logic                      pix_valid,
    input  logic                      pix_last,
    output logic                      pix_ready,
    input  logic                      cmd_request,
    input  logic                      data_request,
    output logic [1:0]                command,
    output logic                      databit,
    output logic                      frame_done,
    output logic                      underrun
);

    localparam logic [COUNTER_SIZE-1:0] CNT_FULL = COUNTER_SIZE'(BITS_PER_PIXEL);
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE  = COUNTER_SIZE'(1);

    logic [BITS_PER_PIXEL-1:0] sh;
    logic [COUNTER_SIZE-1:0]   cnt;
    logic                      sh_last;
    logic                      reset_pending;

    logic [BITS_PER_PIXEL-1:0] hold_data;
    logic                      hold_valid;
    logic                      hold_last;

    logic [BITS_PER_PIXEL-1:0] pix_word;
    logic                      retire;
    logic                      cnt_is_one;
    logic                      pop;
    logic [COUNTER_SIZE-1:0]   cnt_after;
    logic                      accept;
    logic                      to_sh;
    logic                      to_hold;
    logic                      handover;
    logic                      rp_set;
    ws2812_cmd_e               cmd;

`ifdef WS2812_RGB_TO_GRB_EN
    assign pix_word = {swap_bytes(pix_data[BITS_PER_PIXEL-1 -: 16]),
                       pix_data[BITS_PER_PIXEL-17:0]};
`else
    assign pix_word = pix_data;
`endif

    assign retire     = data_request && (cnt != '0);
    assign cnt_is_one = (cnt == CNT_ONE);
    assign pop        = retire && cnt_is_one && hold_valid;
    assign cnt_after  = retire ? (pop ? CNT_FULL : cnt - CNT_ONE) : cnt;
    assign accept     = pix_valid && pix_ready;
    // An incoming pixel goes straight to the shifter only if it would otherwise be empty.
    assign to_sh      = accept && (cnt_after == '0);
    assign to_hold    = accept && (cnt_after != '0);
    assign rp_set     = retire && cnt_is_one && !hold_valid && sh_last;

    always_comb begin
        cmd = CMD_IDLE;
        if (data_request) begin
            if ((cnt > CNT_ONE) || hold_valid)
                cmd = CMD_TX;
            else if ((cnt_is_one && sh_last) || reset_pending)
                cmd = CMD_RESET;
        end else begin
            if (cnt != '0)
                cmd = CMD_TX;
            else if (reset_pending)
                cmd = CMD_RESET;
        end
    end

    assign command  = cmd;
    assign handover = (cmd_request || data_request) && (cmd == CMD_RESET);
    assign databit  = (cnt != '0) ? sh[BITS_PER_PIXEL-1] : 1'b0;

    ws2812_pixel_skid #(
        .W (BITS_PER_PIXEL)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (to_hold),
        .push_data  (pix_word),
        .push_last  (pix_last),
        .pop        (pop),
        .hold_data  (hold_data),
        .hold_valid (hold_valid),
        .hold_last  (hold_last),
        .pix_ready  (pix_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh            <= '0;
            cnt           <= '0;
            sh_last       <= 1'b0;
            reset_pending <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            if (to_sh) begin
                sh      <= pix_word;
                cnt     <= CNT_FULL;
                sh_last <= pix_last;
            end else if (retire) begin
                if (pop) begin
                    sh      <= hold_data;
                    sh_last <= hold_last;
                end else begin
                    sh <= {sh[BITS_PER_PIXEL-2:0], 1'b0};
                end
                cnt <= cnt_after;
            end

            // Handing RESET over wins against a same-edge set so only one RESET is issued.
            if (handover)
                reset_pending <= 1'b0;
            else if (rp_set)
                reset_pending <= 1'b1;

            frame_done <= handover;
            underrun   <= data_request && (cmd == CMD_IDLE) && cnt_is_one;
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Self-checking bench for ws2812_pixel_serializer against a bit-queue reference model.
module tb_ws2812_pixel_serializer;
    import ws2812_pkg::*;

    localparam int BPP = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [BPP-1:0] pix_data = '0;
    logic           pix_valid = 1'b0;
    logic           pix_last = 1'b0;
    logic           pix_ready;
    logic           cmd_request = 1'b0;
    logic           data_request = 1'b0;
    logic [1:0]     command;
    logic           databit;
    logic           frame_done;
    logic           underrun;

    ws2812_pixel_serializer #(.BITS_PER_PIXEL(BPP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_last     (pix_last),
        .pix_ready    (pix_ready),
        .cmd_request  (cmd_request),
        .data_request (data_request),
        .command      (command),
        .databit      (databit),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every buffered bit in transmit order, tagged if it closes a frame.
    typedef struct packed {
        logic b;
        logic endf;
    } mbit_t;
    mbit_t q[$];
    bit    m_rp, m_ready, m_fd, m_ur;

    logic [1:0] o_cmd, e_cmd;
    logic       o_bit, o_ready, o_fd, o_ur;
    logic       e_bit, e_ready, e_fd, e_ur;

    function automatic logic [BPP-1:0] as_stored(input logic [BPP-1:0] p);
`ifdef WS2812_RGB_TO_GRB_EN
        return {p[BPP-9 -: 8], p[BPP-1 -: 8], p[BPP-17:0]};
`else
        return p;
`endif
    endfunction

    function automatic string vec_str();
        return $sformatf("got cmd=%0d bit=%0d rdy=%0d fd=%0d ur=%0d, want cmd=%0d bit=%0d rdy=%0d fd=%0d ur=%0d",
                         o_cmd, o_bit, o_ready, o_fd, o_ur, e_cmd, e_bit, e_ready, e_fd, e_ur);
    endfunction

    task automatic model_reset();
        q.delete();
        m_rp = 0; m_ready = 0; m_fd = 0; m_ur = 0;
    endtask

    // Drive one cycle of inputs, sample outputs on the falling edge, advance the model.
    task automatic tick(input logic dr, input logic cr, input logic pv,
                        input logic [BPP-1:0] pd, input logic pl);
        logic [BPP-1:0] w;
        mbit_t          e;
        bit             acc;
        data_request = dr; cmd_request = cr; pix_valid = pv; pix_data = pd; pix_last = pl;
        @(negedge clk);
        o_cmd = command; o_bit = databit; o_ready = pix_ready; o_fd = frame_done; o_ur = underrun;
        e_bit = (q.size() > 0) ? q[0].b : 1'b0;
        if (dr)
            e_cmd = (q.size() > 1) ? CMD_TX :
                    (((q.size() == 1 && q[0].endf) || m_rp) ? CMD_RESET : CMD_IDLE);
        else
            e_cmd = (q.size() > 0) ? CMD_TX : (m_rp ? CMD_RESET : CMD_IDLE);
        e_ready = m_ready; e_fd = m_fd; e_ur = m_ur;
        acc  = pv && m_ready;
        m_fd = (dr || cr) && (e_cmd == CMD_RESET);
        m_ur = dr && (e_cmd == CMD_IDLE) && (q.size() == 1);
        if (dr && q.size() > 0) begin
            if (q.size() == 1 && q[0].endf) m_rp = 1;
            void'(q.pop_front());
        end
        if (m_fd) m_rp = 0;
        if (acc) begin
            w = as_stored(pd);
            for (int i = BPP - 1; i >= 0; i--) begin
                e.b = w[i];
                e.endf = (i == 0) && pl;
                q.push_back(e);
            end
        end
        m_ready = (q.size() <= BPP);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_request = 1'b1; cmd_request = 1'b1;
        #12;
        n_checks++;
        if ({command, databit, pix_ready, frame_done, underrun} !== {CMD_IDLE, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_state got cmd=%0d bit=%0d rdy=%0d fd=%0d ur=%0d want all zero",
                     command, databit, pix_ready, frame_done, underrun);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(0, 0, 0, '0, 0);
        n_checks++;
        if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
            n_fail++; $display("FAIL reset_release %s", vec_str());
        end
        tick(0, 0, 0, '0, 0);
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after_release got %0d want 1", o_ready);
        end
    endtask

    task automatic test_single_pixel();
        logic [BPP-1:0] got;
        int             fd_cnt = 0;
        tick(0, 1, 1, 24'hA50000, 1);
        n_checks++;
        if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
            n_fail++; $display("FAIL single_offer %s", vec_str());
        end
        tick(0, 1, 0, '0, 0);
        n_checks++;
        if (o_cmd !== CMD_TX) begin
            n_fail++; $display("FAIL single_cmd_request got %0d want %0d", o_cmd, CMD_TX);
        end
        for (int i = 0; i < BPP; i++) begin
            tick(1, 0, 0, '0, 0);
            got[BPP-1-i] = o_bit;
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL single_stream bit%0d %s", i, vec_str());
            end
            if (i == BPP - 1) begin
                n_checks++;
                if (o_cmd !== CMD_RESET) begin
                    n_fail++; $display("FAIL single_last_cmd got %0d want %0d", o_cmd, CMD_RESET);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, '0, 0);
            fd_cnt += int'(o_fd);
        end
        n_checks++;
        if (got !== as_stored(24'hA50000)) begin
            n_fail++; $display("FAIL single_bits got %h want %h", got, as_stored(24'hA50000));
        end
        n_checks++;
        if (fd_cnt != 1) begin
            n_fail++; $display("FAIL single_frame_done got %0d pulses want 1", fd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n_idle = 0, n_reset = 0, fd_cnt = 0;
        tick(0, 0, 1, 24'hFFFFFF, 0);
        tick(0, 0, 1, 24'h000001, 1);
        tick(0, 0, 1, 24'h000001, 1);
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_drop got %0d want 0", o_ready);
        end
        pix_valid = 1'b0;
        for (int i = 0; i < 2 * BPP; i++) begin
            tick(1, 0, 0, '0, 0);
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL b2b_stream bit%0d %s", i, vec_str());
            end
            if (o_cmd == CMD_IDLE) n_idle++;
            if (o_cmd == CMD_RESET) n_reset++;
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, '0, 0);
            fd_cnt += int'(o_fd);
        end
        n_checks++;
        if (n_idle != 0 || n_reset != 1 || fd_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_summary got idle=%0d reset=%0d fd=%0d want 0 1 1", n_idle, n_reset, fd_cnt);
        end
    endtask

    task automatic test_starvation();
        bit done = 0;
        tick(0, 0, 1, 24'h123456, 0);
        for (int i = 0; i < BPP; i++) begin
            tick(1, 0, 0, '0, 0);
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL starve_stream bit%0d %s", i, vec_str());
            end
        end
        n_checks++;
        if (o_cmd !== CMD_IDLE) begin
            n_fail++; $display("FAIL starve_last_cmd got %0d want %0d", o_cmd, CMD_IDLE);
        end
        tick(0, 0, 0, '0, 0);
        n_checks++;
        if (o_ur !== 1'b1) begin
            n_fail++; $display("FAIL starve_underrun got %0d want 1", o_ur);
        end
        tick(0, 0, 1, BPP'($urandom()), 1);
        for (int i = 0; i < 40 && !done; i++) begin
            tick(1, 0, 0, '0, 0);
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL starve_recover %s", vec_str());
            end
            if (o_fd) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL starve_recover_timeout got no frame_done want one");
        end
    endtask

    task automatic test_same_edge();
        logic [BPP-1:0] p2 = BPP'($urandom());
        logic [BPP-1:0] w2 = as_stored(p2);
        logic [BPP-1:0] got;
        tick(0, 0, 1, BPP'($urandom()), 0);
        for (int i = 0; i < BPP - 1; i++) tick(1, 0, 0, '0, 0);
        tick(1, 0, 1, p2, 1);
        n_checks++;
        if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
            n_fail++; $display("FAIL same_edge_handoff %s", vec_str());
        end
        for (int i = 0; i < BPP; i++) begin
            tick(1, 0, 0, '0, 0);
            got[BPP-1-i] = o_bit;
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL same_edge_stream bit%0d %s", i, vec_str());
            end
        end
        n_checks++;
        if (got !== w2) begin
            n_fail++; $display("FAIL same_edge_word got %h want %h", got, w2);
        end
        tick(0, 0, 0, '0, 0);
        tick(0, 0, 0, '0, 0);
    endtask

    task automatic test_reset_mid_pixel();
        tick(0, 0, 1, BPP'($urandom()), 0);
        for (int i = 0; i < BPP - 10; i++) tick(1, 0, 0, '0, 0);
        data_request = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({command, databit, pix_ready} !== {CMD_IDLE, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got cmd=%0d bit=%0d rdy=%0d want 0 0 0", command, databit, pix_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick(0, 0, 0, '0, 0);
        n_checks++;
        if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
            n_fail++; $display("FAIL reset_mid_release %s", vec_str());
        end
        tick(0, 0, 0, '0, 0);
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_ready got %0d want 1", o_ready);
        end
    endtask

`ifdef WS2812_RGB_TO_GRB_EN
    task automatic test_rgb_swap();
        logic [BPP-1:0] got;
        tick(0, 0, 1, 24'h112233, 1);
        for (int i = 0; i < BPP; i++) begin
            tick(1, 0, 0, '0, 0);
            got[BPP-1-i] = o_bit;
        end
        n_checks++;
        if (got !== 24'h221133) begin
            n_fail++; $display("FAIL rgb_swap got %h want 221133", got);
        end
        tick(0, 0, 0, '0, 0);
        tick(0, 0, 0, '0, 0);
    endtask
`endif

    task automatic test_random();
        int guard = 0;
        for (int i = 0; i < 600; i++) begin
            tick(($urandom() % 4) != 0, ($urandom() % 2) != 0, ($urandom() % 2) != 0,
                 BPP'($urandom()), ($urandom() % 4) == 0);
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL random_cycle%0d %s", i, vec_str());
            end
        end
        while ((q.size() != 0 || m_rp || m_fd) && guard < 200) begin
            tick(1, 0, 0, '0, 0);
            guard++;
            n_checks++;
            if ({o_cmd, o_bit, o_ready, o_fd, o_ur} !== {e_cmd, e_bit, e_ready, e_fd, e_ur}) begin
                n_fail++; $display("FAIL random_drain %s", vec_str());
            end
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++; $display("FAIL random_drain_timeout got %0d bits left want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_starvation();
        test_same_edge();
        test_reset_mid_pixel();
`ifdef WS2812_RGB_TO_GRB_EN
        test_rgb_swap();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
